// File: rtl/mprj_io_cfg_loader.sv
// mprj_io_cfg_loader
// Holds one configuration word per user-project GPIO pad and, on command,
// shifts every word out over two parallel serial chains (user1 side and
// user2 side), then pulses a load strobe so the pads latch their new setup.
//
// Optional build macro: MPRJ_CFG_AUTOLOAD_EN
//   When defined, a transfer starts by itself in the first cycle after
//   serial_resetn returns high, so the pads receive CFG_DEFAULT with no
//   software action. Writes in that cycle are rejected with cfg_wr_err.
//   When undefined, the controller waits in IDLE for xfer_start.
//
// Handshake: xfer_start is a level sampled only in IDLE. xfer_busy is high
// from the cycle after the start is accepted until the last load cycle.
// xfer_done is a single-cycle pulse that follows, with xfer_busy low.
// Starts seen while busy or during the done cycle are ignored, not queued.
// Config writes are accepted only in IDLE; a write while busy is dropped
// and flagged by a one-cycle cfg_wr_err pulse in the following cycle.
//
// The FSM state is visible on o_dbg_state for checkers.
module mprj_io_cfg_loader #(
    parameter int                  NUM_PADS_1  = 19,
    parameter int                  NUM_PADS_2  = 19,
    parameter int                  CFG_BITS    = 13,
    parameter int                  CLK_DIV     = 4,
    parameter logic [CFG_BITS-1:0] CFG_DEFAULT = 13'h0403
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_wr_en,
    input  logic [5:0]          cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_wr_data,
    output logic [CFG_BITS-1:0] cfg_rd_data,
    output logic                cfg_wr_err,
    input  logic                xfer_start,
    output logic                xfer_busy,
    output logic                xfer_done,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                serial_resetn,
    output logic                serial_data_1,
    output logic                serial_data_2,
    output logic [2:0]          o_dbg_state
);

    // Pad counts and counter widths. The word counter walks the longer
    // chain; a shorter chain simply outputs zero for slots it does not own,
    // which front-pads it so both chains end on the same bit.
    localparam int NUM_PADS = NUM_PADS_1 + NUM_PADS_2;
    localparam int MAXP     = (NUM_PADS_1 > NUM_PADS_2) ? NUM_PADS_1 : NUM_PADS_2;
    localparam int AW       = $clog2(NUM_PADS);
    localparam int WW       = (MAXP > 1) ? $clog2(MAXP) : 1;
    localparam int BW       = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_CLK_HI = 3'd2,
        S_LOAD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_div;
    logic [WW-1:0]       r_word;
    logic [BW-1:0]       r_bit;
    logic [CFG_BITS-1:0] r_cfg [NUM_PADS];
    logic                r_rstn;
    logic                r_wr_err;

    logic                w_auto;
    logic                w_start;
    logic                w_div_end;
    logic                w_last;
    logic                w_busy;
    logic                w_addr_ok;
    logic                w_wr_ok;
    logic                w_wr_rej;
    logic                w_cnt_init;
    logic                w_cnt_step;
    logic                w_shift;
    logic                w_in1;
    logic                w_in2;
    logic [AW-1:0]       w_pad1;
    logic [AW-1:0]       w_pad2;

    // ------------------------------------------------------------------
    // Chain reset: held low through reset and one cycle beyond it.
    // ------------------------------------------------------------------

    // Registered active-low chain reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rstn <= 1'b0;
        end else begin
            r_rstn <= 1'b1;
        end
    end

`ifdef MPRJ_CFG_AUTOLOAD_EN
    logic r_rstn_q;

    // Delayed copy of the chain reset, used to find its rising edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rstn_q <= 1'b0;
        end else begin
            r_rstn_q <= r_rstn;
        end
    end

    assign w_auto = r_rstn & ~r_rstn_q;
`else
    assign w_auto = 1'b0;
`endif

    assign w_start = xfer_start | w_auto;

    // ------------------------------------------------------------------
    // Config word store and readback.
    // ------------------------------------------------------------------

    assign w_addr_ok = int'(cfg_addr) < NUM_PADS;
    assign w_busy    = (r_state == S_SETUP) || (r_state == S_CLK_HI) || (r_state == S_LOAD);
    assign w_wr_ok   = cfg_wr_en && w_addr_ok && (r_state == S_IDLE) && !w_auto;
    assign w_wr_rej  = cfg_wr_en && (w_busy || w_auto);

    assign cfg_rd_data = w_addr_ok ? r_cfg[cfg_addr[AW-1:0]] : '0;

    // Word storage: defaults on reset, otherwise accept writes only in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                r_cfg[i] <= CFG_DEFAULT;
            end
        end else if (w_wr_ok) begin
            r_cfg[cfg_addr[AW-1:0]] <= cfg_wr_data;
        end
    end

    // One-cycle error pulse for a write that arrived while busy.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_rej;
        end
    end

    assign cfg_wr_err = r_wr_err;

    // ------------------------------------------------------------------
    // Sequencer.
    // ------------------------------------------------------------------

    assign w_div_end = (r_div == 8'(CLK_DIV - 1));
    assign w_last    = (r_word == '0) && (r_bit == '0);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        w_next       = r_state;
        w_cnt_init   = 1'b0;
        w_cnt_step   = 1'b0;
        serial_clock = 1'b0;
        serial_load  = 1'b0;
        xfer_busy    = 1'b0;
        xfer_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next     = S_SETUP;
                    w_cnt_init = 1'b1;
                end
            end
            S_SETUP: begin
                xfer_busy = 1'b1;
                if (w_div_end) begin
                    w_next = S_CLK_HI;
                end
            end
            S_CLK_HI: begin
                xfer_busy    = 1'b1;
                serial_clock = 1'b1;
                if (w_div_end) begin
                    if (w_last) begin
                        w_next = S_LOAD;
                    end else begin
                        w_next     = S_SETUP;
                        w_cnt_step = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                xfer_busy   = 1'b1;
                serial_load = 1'b1;
                if (w_div_end) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                xfer_done = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Phase divider: counts cycles within SETUP/CLK_HI/LOAD, clears on exit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_busy && !w_div_end) begin
            r_div <= r_div + 8'd1;
        end else begin
            r_div <= '0;
        end
    end

    // Bit position: word slot counts down from the farthest pad, bit counts
    // down from the MSB of each word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_word <= '0;
            r_bit  <= '0;
        end else if (w_cnt_init) begin
            r_word <= WW'(MAXP - 1);
            r_bit  <= BW'(CFG_BITS - 1);
        end else if (w_cnt_step) begin
            if (r_bit == '0) begin
                r_bit  <= BW'(CFG_BITS - 1);
                r_word <= r_word - WW'(1);
            end else begin
                r_bit  <= r_bit - BW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Serial data: word slot r_word maps to chain-local pad r_word; slots
    // beyond a chain's length are padding and send zero.
    // ------------------------------------------------------------------

    assign w_shift = (r_state == S_SETUP) || (r_state == S_CLK_HI);
    assign w_in1   = int'(r_word) < NUM_PADS_1;
    assign w_in2   = int'(r_word) < NUM_PADS_2;
    assign w_pad1  = AW'(int'(r_word));
    assign w_pad2  = AW'(NUM_PADS_1 + int'(r_word));

    assign serial_data_1 = w_shift && w_in1 && r_cfg[w_pad1][r_bit];
    assign serial_data_2 = w_shift && w_in2 && r_cfg[w_pad2][r_bit];

    assign serial_resetn = r_rstn;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// tb_mprj_io_cfg_loader
// Directed bench for mprj_io_cfg_loader. Two instances share one clock:
// u_dut with default parameters (timing, blocking, reset abort) and u_small
// with 2+1 pads of 4 bits and CLK_DIV=1 (bit ordering and padding).
// Honours MPRJ_CFG_AUTOLOAD_EN when the design is built with it.
module tb_mprj_io_cfg_loader;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    // default-parameter instance
    logic        d_reset, d_wr_en, d_start;
    logic [5:0]  d_addr;
    logic [12:0] d_wdata, d_rd;
    logic        d_err, d_busy, d_done, d_sclk, d_load, d_rstn, d_sd1, d_sd2;
    logic [2:0]  d_dbg;

    // small instance
    logic        s_reset, s_wr_en, s_start;
    logic [5:0]  s_addr;
    logic [3:0]  s_wdata, s_rd;
    logic        s_err, s_busy, s_done, s_sclk, s_load, s_rstn, s_sd1, s_sd2;
    logic [2:0]  s_dbg;

    mprj_io_cfg_loader u_dut (
        .clock(clock), .reset(d_reset), .cfg_wr_en(d_wr_en), .cfg_addr(d_addr),
        .cfg_wr_data(d_wdata), .cfg_rd_data(d_rd), .cfg_wr_err(d_err),
        .xfer_start(d_start), .xfer_busy(d_busy), .xfer_done(d_done),
        .serial_clock(d_sclk), .serial_load(d_load), .serial_resetn(d_rstn),
        .serial_data_1(d_sd1), .serial_data_2(d_sd2), .o_dbg_state(d_dbg)
    );

    mprj_io_cfg_loader #(
        .NUM_PADS_1(2), .NUM_PADS_2(1), .CFG_BITS(4), .CLK_DIV(1), .CFG_DEFAULT(4'h3)
    ) u_small (
        .clock(clock), .reset(s_reset), .cfg_wr_en(s_wr_en), .cfg_addr(s_addr),
        .cfg_wr_data(s_wdata), .cfg_rd_data(s_rd), .cfg_wr_err(s_err),
        .xfer_start(s_start), .xfer_busy(s_busy), .xfer_done(s_done),
        .serial_clock(s_sclk), .serial_load(s_load), .serial_resetn(s_rstn),
        .serial_data_1(s_sd1), .serial_data_2(s_sd2), .o_dbg_state(s_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] exp_q[$];   // {chain1 bit, chain2 bit} in shift order

    int first_busy, last_busy, done_cyc, done_cnt, load_cnt, edges;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_stats();
        first_busy = -1; last_busy = -1; done_cyc = -1;
        done_cnt = 0; load_cnt = 0; edges = 0;
    endtask

    // Watches u_dut for ncyc cycles after a start placed in cycle 0.
    // pokes: blocked write at cycle 10, extra start at cycle 20.
    // abort_cyc > 0: reset driven during that cycle.
    task automatic mon_default(input int ncyc, input bit pokes, input int abort_cyc);
        logic prev_sclk;
        prev_sclk = 1'b0;
        clr_stats();
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            tick();
            d_start = 1'b0;
            d_wr_en = 1'b0;
            d_reset = 1'b0;
            if (d_busy) begin
                if (first_busy < 0) first_busy = cyc;
                last_busy = cyc;
            end
            if (d_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (d_load) load_cnt++;
            if (d_sclk && !prev_sclk) edges++;
            prev_sclk = d_sclk;
            if (pokes && cyc == 10) begin
                d_wr_en = 1'b1; d_addr = 6'd3; d_wdata = 13'h1FFF;
            end
            if (pokes && cyc == 11) begin
                check("busy_wr_err_pulse", d_err, 1);
                check("busy_wr_addr3_kept", d_rd, 13'h0403);
            end
            if (pokes && cyc == 12) check("busy_wr_err_one_cycle", d_err, 0);
            if (pokes && cyc == 20) d_start = 1'b1;
            if (cyc == abort_cyc) d_reset = 1'b1;
            if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
                check("abort_busy", d_busy, 0);
                check("abort_done", d_done, 0);
                check("abort_sclk", d_sclk, 0);
                check("abort_load", d_load, 0);
                check("abort_sd1", d_sd1, 0);
                check("abort_sd2", d_sd2, 0);
                check("abort_err", d_err, 0);
                check("abort_rstn", d_rstn, 0);
                check("abort_state", d_dbg, 0);
                check("abort_word5_default", d_rd, 13'h0403);
            end
        end
    endtask

    // Runs one small transfer (start already placed in cycle 0) and checks
    // bit order against c1/c2 and the 18-cycle timing.
    task automatic mon_small(input logic [7:0] c1, input logic [7:0] c2);
        logic prev_sclk;
        logic [1:0] e;
        prev_sclk = 1'b0;
        exp_q.delete();
        for (int i = 7; i >= 0; i--) exp_q.push_back({c1[i], c2[i]});
        clr_stats();
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            s_start = 1'b0;
            s_wr_en = 1'b0;
            if (s_busy) begin
                if (first_busy < 0) first_busy = cyc;
                last_busy = cyc;
            end
            if (s_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (s_load) load_cnt++;
            if (s_sclk && !prev_sclk) begin
                edges++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("small_chain1_bit", s_sd1, e[1]);
                    check("small_chain2_bit", s_sd2, e[0]);
                end
            end
            prev_sclk = s_sclk;
        end
        check("small_bits_left", exp_q.size(), 0);
        check("small_edges", edges, 8);
        check("small_first_busy", first_busy, 1);
        check("small_last_busy", last_busy, 17);
        check("small_done_cycle", done_cyc, 18);
        check("small_done_count", done_cnt, 1);
        check("small_load_cycles", load_cnt, 1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((d_busy || d_done) && n < bound) begin
            tick();
            n++;
        end
        check("wait_idle_bound", (d_busy || d_done) ? 0 : 1, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        d_reset = 1'b1; d_wr_en = 1'b0; d_start = 1'b0; d_addr = '0; d_wdata = '0;
        s_reset = 1'b1; s_wr_en = 1'b0; s_start = 1'b0; s_addr = '0; s_wdata = '0;
        tick();
        tick();

        // reset values
        check("rst_busy", d_busy, 0);
        check("rst_done", d_done, 0);
        check("rst_err", d_err, 0);
        check("rst_sclk", d_sclk, 0);
        check("rst_load", d_load, 0);
        check("rst_sd1", d_sd1, 0);
        check("rst_sd2", d_sd2, 0);
        check("rst_rstn", d_rstn, 0);
        check("rst_state", d_dbg, 0);
        check("rst_small_rstn", s_rstn, 0);

        // release reset: chain reset stays low this cycle, high the next
        d_reset = 1'b0;
        s_reset = 1'b0;
        #1;
        check("rstn_low_after_release", d_rstn, 0);
        tick();
        check("rstn_high", d_rstn, 1);
        check("small_rstn_high", s_rstn, 1);

        // default readback
        d_addr = 6'd0;  #1; check("rd_addr0", d_rd, 13'h0403);
        d_addr = 6'd18; #1; check("rd_addr18", d_rd, 13'h0403);
        d_addr = 6'd37; #1; check("rd_addr37", d_rd, 13'h0403);
        d_addr = 6'd40; #1; check("rd_addr40_oor", d_rd, 0);
        s_addr = 6'd0;  #1; check("small_rd_default", s_rd, 4'h3);

`ifdef MPRJ_CFG_AUTOLOAD_EN
        // this cycle is the first with serial_resetn high: autoload starts
        mon_default(2100, 1'b0, 0);
        check("auto_first_busy", first_busy, 1);
        check("auto_last_busy", last_busy, 1980);
        check("auto_done_cycle", done_cyc, 1981);
        check("auto_edges", edges, 247);
`endif

        // small instance: writes, including an aliasing out-of-range address
        tick();
        s_wr_en = 1'b1; s_addr = 6'd1; s_wdata = 4'hA; tick();
        s_addr = 6'd0; s_wdata = 4'h5; tick();
        s_addr = 6'd2; s_wdata = 4'hC; tick();
        s_addr = 6'd6; s_wdata = 4'h9; tick();
        s_wr_en = 1'b0;
        s_addr = 6'd1; #1; check("small_rd_pad1", s_rd, 4'hA);
        s_addr = 6'd0; #1; check("small_rd_pad0", s_rd, 4'h5);
        s_addr = 6'd2; #1; check("small_rd_pad2_no_alias", s_rd, 4'hC);
        s_addr = 6'd3; #1; check("small_rd_oor", s_rd, 0);

        s_start = 1'b1;
        mon_small(8'b1010_0101, 8'b0000_1100);

        // write and start in the same cycle: transfer uses the new word
        s_wr_en = 1'b1; s_addr = 6'd0; s_wdata = 4'h3; s_start = 1'b1;
        mon_small(8'b1010_0011, 8'b0000_1100);

        // default instance: full transfer with a blocked write and extra start
        wait_idle(3000);
        d_start = 1'b1;
        mon_default(2100, 1'b1, 0);
        check("dflt_first_busy", first_busy, 1);
        check("dflt_last_busy", last_busy, 1980);
        check("dflt_done_cycle", done_cyc, 1981);
        check("dflt_done_count", done_cnt, 1);
        check("dflt_edges", edges, 247);
        check("dflt_load_cycles", load_cnt, 4);
        d_addr = 6'd3; #1; check("dflt_addr3_after", d_rd, 13'h0403);

        // reset in the middle of a transfer
        d_wr_en = 1'b1; d_addr = 6'd5; d_wdata = 13'h0AAA; tick();
        d_wr_en = 1'b0; #1;
        check("idle_wr_addr5", d_rd, 13'h0AAA);
        d_start = 1'b1;
        mon_default(520, 1'b0, 500);
        check("abort_no_load", load_cnt, 0);
        check("abort_no_done", done_cnt, 0);

        // fresh transfer after the abort
        wait_idle(3000);
        d_start = 1'b1;
        mon_default(2000, 1'b0, 0);
        check("fresh_first_busy", first_busy, 1);
        check("fresh_last_busy", last_busy, 1980);
        check("fresh_done_cycle", done_cyc, 1981);
        check("fresh_load_cycles", load_cnt, 4);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
